// File: rtl/bus_timer_if.sv
// Address and strobe group of the shared CPU bus, plus the timer interrupt line.
// bus_data stays a plain inout on the responder because it is a resolved tri-state net.
interface bus_timer_if #(
    parameter int unsigned ADDR_WIDTH = 20
) ();
    logic [ADDR_WIDTH-1:0] bus_addr;
    logic                  read;
    logic                  write;
    logic                  irq;

    modport master (
        output bus_addr,
        output read,
        output write,
        input  irq
    );

    modport slave (
        input  bus_addr,
        input  read,
        input  write,
        output irq
    );
endinterface

// File: rtl/bus_timer.sv
// Memory-mapped down-counting timer with prescaler, auto-reload and level interrupt.
// Five word registers at START_ADDRESS: CTRL, PRESC, RELOAD, COUNT, STATUS (W1C).
module bus_timer #(
    parameter int unsigned           ADDR_WIDTH    = 20,
    parameter int unsigned           DATA_WIDTH    = 16,
    parameter logic [ADDR_WIDTH-1:0] START_ADDRESS = 20'h00400
) (
    input  logic                  clk,
    input  logic                  reset,
    inout  wire  [DATA_WIDTH-1:0] bus_data,
    bus_timer_if.slave            bus
);
    logic [2:0]            ctrl_q;
    logic [DATA_WIDTH-1:0] presc_q;
    logic [DATA_WIDTH-1:0] reload_q;
    logic [DATA_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] prescaler_q;
    logic                  exp_q;

    logic [ADDR_WIDTH-1:0] off;
    logic                  hit;
    logic                  wr_stb;
    logic                  bus_drive;
    logic [DATA_WIDTH-1:0] rdata;
    logic                  en;
    logic                  tick;
    logic                  expiry;

    assign off       = bus.bus_addr - START_ADDRESS;
    assign hit       = (bus.bus_addr >= START_ADDRESS) && (off < ADDR_WIDTH'(5));
    assign wr_stb    = bus.write && hit;
    assign bus_drive = bus.read && hit && !bus.write;

    always_comb begin
        rdata = '0;
        case (off[2:0])
            3'd0:    rdata = DATA_WIDTH'(ctrl_q);
            3'd1:    rdata = presc_q;
            3'd2:    rdata = reload_q;
            3'd3:    rdata = count_q;
            3'd4:    rdata = DATA_WIDTH'(exp_q);
            default: rdata = '0;
        endcase
    end

    assign bus_data = bus_drive ? rdata : 'z;

    assign en     = ctrl_q[0];
    assign tick   = en && (prescaler_q == presc_q);
    assign expiry = tick && (count_q == '0);

    assign bus.irq = exp_q & ctrl_q[2];

    // CPU writes are placed last so they override counter updates on the same edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl_q      <= '0;
            presc_q     <= '0;
            reload_q    <= '0;
            count_q     <= '0;
            prescaler_q <= '0;
            exp_q       <= 1'b0;
        end else begin
            if (en) begin
                prescaler_q <= tick ? '0 : prescaler_q + DATA_WIDTH'(1);
            end
            if (tick) begin
                if (count_q != '0) begin
                    count_q <= count_q - DATA_WIDTH'(1);
                end else if (ctrl_q[1]) begin
                    count_q <= reload_q;
                end
            end
            if (expiry && !ctrl_q[1]) begin
                ctrl_q[0] <= 1'b0;
            end
            // Expiry set beats a simultaneous W1C clear.
            if (expiry) begin
                exp_q <= 1'b1;
            end else if (wr_stb && (off[2:0] == 3'd4) && bus_data[0]) begin
                exp_q <= 1'b0;
            end
            if (wr_stb) begin
                case (off[2:0])
                    3'd0: ctrl_q   <= bus_data[2:0];
                    3'd1: presc_q  <= bus_data;
                    3'd2: reload_q <= bus_data;
                    3'd3: begin
                        count_q     <= bus_data;
                        prescaler_q <= '0;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_bus_timer.sv
// Self-checking bench for bus_timer: expected read values go through a scoreboard queue.
module tb_bus_timer;
    localparam int unsigned AW   = 20;
    localparam int unsigned DW   = 16;
    localparam logic [AW-1:0] BASE = 20'h00400;

    logic          clk;
    logic          reset;
    wire  [DW-1:0] bus_data;
    logic [DW-1:0] drv_data;
    logic          drv_en;

    int n_vec;
    int n_err;
    logic [31:0] sb[$];

    bus_timer_if #(.ADDR_WIDTH(AW)) bus_if ();

    assign bus_data = drv_en ? drv_data : 'z;

    bus_timer #(
        .ADDR_WIDTH   (AW),
        .DATA_WIDTH   (DW),
        .START_ADDRESS(BASE)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus_data(bus_data),
        .bus     (bus_if.slave)
    );

    initial clk = 1'b0;
    always #20 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Combinational read; consumes 2 time units and no clock edge.
    task automatic rd(input string tag, input int off, input logic [DW-1:0] exp);
        sb.push_back(32'(exp));
        bus_if.bus_addr = BASE + AW'(off);
        bus_if.read     = 1'b1;
        #1;
        check_val({tag, ".drv"}, 32'(dut.bus_drive), 32'd1);
        check_val(tag, 32'(bus_data), sb.pop_front());
        bus_if.read = 1'b0;
        #1;
    endtask

    task automatic rd_none(input string tag, input logic [AW-1:0] addr);
        sb.push_back(32'd0);
        bus_if.bus_addr = addr;
        bus_if.read     = 1'b1;
        #1;
        check_val(tag, 32'(dut.bus_drive), sb.pop_front());
        bus_if.read = 1'b0;
        #1;
    endtask

    task automatic chk_irq(input string tag, input logic exp);
        sb.push_back(32'(exp));
        check_val(tag, 32'(bus_if.irq), sb.pop_front());
    endtask

    // Write is captured on the next rising edge; returns 1 unit after it.
    task automatic wr(input int off, input logic [DW-1:0] data);
        bus_if.bus_addr = BASE + AW'(off);
        drv_data        = data;
        drv_en          = 1'b1;
        bus_if.write    = 1'b1;
        @(posedge clk);
        #1;
        bus_if.write = 1'b0;
        drv_en       = 1'b0;
    endtask

    task automatic edges(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        reset = 1'b0;
        drv_en = 1'b0;
        drv_data = '0;
        bus_if.bus_addr = '0;
        bus_if.read = 1'b0;
        bus_if.write = 1'b0;

        // Reset
        edges(2);
        rd("rst_ctrl_in_reset", 0, 16'h0);
        reset = 1'b1;
        edges(1);
        for (int i = 0; i < 5; i++) begin
            rd($sformatf("rst_off%0d", i), i, 16'h0);
            if (i == 3) edges(1);
        end
        rd_none("nodrv_off5", BASE + 20'd5);
        rd_none("nodrv_below", BASE - 20'd1);
        chk_irq("rst_irq", 1'b0);

        // One-shot: expiry 4 edges after EN
        wr(1, 16'd0);
        wr(3, 16'd3);
        wr(0, 16'h5);
        edges(3);
        rd("os_exp_early", 4, 16'h0);
        chk_irq("os_irq_early", 1'b0);
        edges(1);
        rd("os_exp", 4, 16'h1);
        chk_irq("os_irq", 1'b1);
        rd("os_ctrl", 0, 16'h4);
        rd("os_count", 3, 16'h0);
        edges(3);
        rd("os_count_hold", 3, 16'h0);
        wr(4, 16'h1);
        rd("w1c_clear", 4, 16'h0);
        chk_irq("w1c_irq", 1'b0);

        // Auto-reload with prescale 3
        wr(1, 16'd2);
        wr(2, 16'd1);
        wr(3, 16'd1);
        wr(0, 16'h3);
        edges(5);
        rd("ar_exp_early", 4, 16'h0);
        rd("ar_count_mid", 3, 16'h0);
        edges(1);
        rd("ar_exp", 4, 16'h1);
        rd("ar_reload", 3, 16'h1);
        rd("ar_ctrl", 0, 16'h3);
        // Clear at X+1, then collide a clear with the X+6 expiry
        wr(4, 16'h1);
        rd("ar_clear", 4, 16'h0);
        edges(3);
        rd("ar2_early", 4, 16'h0);
        rd("ar2_count", 3, 16'h0);
        edges(1);
        wr(4, 16'h1);
        rd("collide_exp", 4, 16'h1);
        rd("ar2_reload", 3, 16'h1);
        rd("ar2_ctrl", 0, 16'h3);
        wr(4, 16'h0);
        rd("w0_nochange", 4, 16'h1);
        wr(4, 16'h1);
        rd("w1c_again", 4, 16'h0);

        // Write priority over a tick
        wr(0, 16'h0);
        wr(3, 16'd5);
        wr(0, 16'h1);
        edges(1);
        wr(3, 16'd9);
        rd("prio_count", 3, 16'd9);
        check_val("prio_prescaler", 32'(dut.prescaler_q), 32'd0);
        edges(2);
        rd("prio_hold", 3, 16'd9);
        edges(1);
        rd("prio_dec", 3, 16'd8);

        // CTRL write beats expiry clearing EN
        wr(0, 16'h0);
        wr(1, 16'd0);
        wr(3, 16'd0);
        wr(4, 16'h1);
        wr(0, 16'h1);
        wr(0, 16'h5);
        rd("ctrlprio_ctrl", 0, 16'h5);
        rd("ctrlprio_exp", 4, 16'h1);

        // Async reset mid-run
        wr(3, 16'd20);
        wr(0, 16'h7);
        edges(2);
        rd("pre_rst_count", 3, 16'd18);
        chk_irq("pre_rst_irq", 1'b1);
        #3;
        reset = 1'b0;
        #1;
        chk_irq("async_irq", 1'b0);
        rd("async_count", 3, 16'd0);
        rd("async_ctrl", 0, 16'd0);
        reset = 1'b1;
        edges(3);
        rd("post_rst_count", 3, 16'd0);
        rd("post_rst_exp", 4, 16'd0);
        check_val("post_rst_prescaler", 32'(dut.prescaler_q), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
